// File: rtl/light_pkg.sv
// Shared definitions for the light request conditioner.
//   - Light codes driven back by the downstream traffic-light controller.
//   - Per-approach request FSM state type and encodings.
//   - Positions of the four approach queue sensors within sensor_raw.
package light_pkg;

    localparam logic [2:0] STOP         = 3'b000;
    localparam logic [2:0] FORWARD_ONLY = 3'b001;
    localparam logic [2:0] LEFT_ONLY    = 3'b010;
    localparam logic [2:0] RIGHT_ONLY   = 3'b011;
    localparam logic [2:0] GO           = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAITING = 2'd1,
        ST_SERVED  = 2'd2
    } appr_state_t;

    localparam int SEN_SOUTH = 4;
    localparam int SEN_EAST  = 5;
    localparam int SEN_NORTH = 6;
    localparam int SEN_WEST  = 7;

endpackage

// File: rtl/sensor_debounce.sv
// Single-bit sensor debouncer.
// clean follows raw only after raw has differed from clean for
// DEBOUNCE_CYCLES consecutive samples; shorter glitches are dropped.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous reset, active-low
//   raw   in  raw sensor bit
//   clean out debounced sensor bit
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            clean <= 1'b0;
        end else if (raw != clean) begin
            // The first differing sample counts as sample 0, so the toggle
            // lands exactly DEBOUNCE_CYCLES edges after the change.
            if (count == LAST) begin
                clean <= raw;
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else begin
            count <= '0;
        end
    end

endmodule

// File: rtl/light_request_conditioner.sv
// Conditions raw car-presence sensors for a traffic-light controller.
// Debounces all 8 sensors and keeps a per-approach request FSM with a
// saturating wait-age counter, using the controller's light codes as
// "served" feedback.
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous reset, active-low
//   sensor_raw     in   [7:0] raw sensors (3:0 interior, 4 S, 5 E, 6 N, 7 W)
//   light_n/s/e/w  in   [2:0] current light code per approach
//   sensor_clean   out  [7:0] debounced sensors
//   req            out  [3:0] {W,E,S,N} unserved waiting car
//   urgent         out  [3:0] {W,E,S,N} req with age >= URGENT_AGE
//   age_n/s/e/w    out  [AGE_W-1:0] wait age per approach
//   busy           out  interior occupied
//   debug_port     out  [29:0] only when LIGHT_COND_DEBUG_EN is defined
// Configuration macro: LIGHT_COND_DEBUG_EN adds debug_port.
module light_request_conditioner
    import light_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AGE_W           = 8,
    parameter int URGENT_AGE      = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       sensor_raw,
    input  logic [2:0]       light_n,
    input  logic [2:0]       light_s,
    input  logic [2:0]       light_e,
    input  logic [2:0]       light_w,
    output logic [7:0]       sensor_clean,
    output logic [3:0]       req,
    output logic [3:0]       urgent,
    output logic [AGE_W-1:0] age_n,
    output logic [AGE_W-1:0] age_s,
    output logic [AGE_W-1:0] age_e,
    output logic [AGE_W-1:0] age_w,
    output logic             busy
`ifdef LIGHT_COND_DEBUG_EN
    ,
    output logic [29:0]      debug_port
`endif
);

    localparam logic [AGE_W-1:0] URGENT_TH = AGE_W'(URGENT_AGE);

    for (genvar i = 0; i < 8; i++) begin : g_deb
        sensor_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .raw  (sensor_raw[i]),
            .clean(sensor_clean[i])
        );
    end

    assign busy = |sensor_clean[3:0];

    // Approach order {W,E,S,N} matches the req/urgent bit order.
    logic [3:0] appr_clean;
    logic [3:0] appr_served;
    logic [3:0][AGE_W-1:0] age_all;

    assign appr_clean  = {sensor_clean[SEN_WEST], sensor_clean[SEN_EAST],
                          sensor_clean[SEN_SOUTH], sensor_clean[SEN_NORTH]};
    assign appr_served = {light_w != STOP, light_e != STOP,
                          light_s != STOP, light_n != STOP};

`ifdef LIGHT_COND_DEBUG_EN
    logic [3:0][1:0] state_all;
`endif

    for (genvar d = 0; d < 4; d++) begin : g_appr
        appr_state_t      state, next_state;
        logic [AGE_W-1:0] age_q, age_next;
        logic             req_q;

        always_comb begin
            next_state = state;
            case (state)
                ST_IDLE: begin
                    // A car arriving while its light is already on never requests.
                    if (appr_clean[d] && appr_served[d]) next_state = ST_SERVED;
                    else if (appr_clean[d])              next_state = ST_WAITING;
                end
                ST_WAITING: begin
                    if (appr_served[d])     next_state = ST_SERVED;
                    else if (!appr_clean[d]) next_state = ST_IDLE;
                end
                ST_SERVED: begin
                    if (!appr_served[d]) next_state = appr_clean[d] ? ST_WAITING : ST_IDLE;
                end
                default: next_state = ST_IDLE;
            endcase

            // Age is zero on entry to WAITING and on every exit from it.
            age_next = '0;
            if (state == ST_WAITING && next_state == ST_WAITING) begin
                age_next = (age_q == '1) ? age_q : age_q + AGE_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state <= ST_IDLE;
                age_q <= '0;
                req_q <= 1'b0;
            end else begin
                state <= next_state;
                age_q <= age_next;
                req_q <= (next_state == ST_WAITING);
            end
        end

        assign req[d]     = req_q;
        assign urgent[d]  = req_q && (age_q >= URGENT_TH);
        assign age_all[d] = age_q;
`ifdef LIGHT_COND_DEBUG_EN
        assign state_all[d] = state;
`endif
    end

    assign age_n = age_all[0];
    assign age_s = age_all[1];
    assign age_e = age_all[2];
    assign age_w = age_all[3];

`ifdef LIGHT_COND_DEBUG_EN
    // Low 8 bits of an age, zero-extended when AGE_W is narrower.
    function automatic logic [7:0] low8(input logic [AGE_W-1:0] a);
        logic [AGE_W+7:0] t;
        t = {8'b0, a};
        return t[7:0];
    endfunction

    assign debug_port = {low8(age_all[0]), low8(age_all[1]),
                         state_all[3], state_all[2], state_all[1], state_all[0],
                         6'b0};
`endif

endmodule

// File: tb/tb_light_request_conditioner.sv
module tb_light_request_conditioner;

    logic       clk;
    logic       rst;
    logic [7:0] sensor_raw;
    logic [2:0] light_n, light_s, light_e, light_w;
    logic [7:0] sensor_clean;
    logic [3:0] req, urgent;
    logic [7:0] age_n, age_s, age_e, age_w;
    logic       busy;
`ifdef LIGHT_COND_DEBUG_EN
    logic [29:0] debug_port;
`endif

    int n_vec = 0;
    int n_err = 0;

    light_request_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .AGE_W(8),
        .URGENT_AGE(200)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sensor_raw  (sensor_raw),
        .light_n     (light_n),
        .light_s     (light_s),
        .light_e     (light_e),
        .light_w     (light_w),
        .sensor_clean(sensor_clean),
        .req         (req),
        .urgent      (urgent),
        .age_n       (age_n),
        .age_s       (age_s),
        .age_e       (age_e),
        .age_w       (age_w),
        .busy        (busy)
`ifdef LIGHT_COND_DEBUG_EN
        ,
        .debug_port  (debug_port)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sensor_raw = 8'h00;
        light_n = 3'b000; light_s = 3'b000; light_e = 3'b000; light_w = 3'b000;
        tick(2);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        sensor_raw = 8'hFF;
        light_n = 3'b000; light_s = 3'b000; light_e = 3'b000; light_w = 3'b000;
        tick(3);
        n_vec++;
        if ({sensor_clean, req, urgent, age_n, age_s, age_e, age_w, busy} !== 49'd0) begin
            n_err++;
            $display("FAIL reset_outputs: clean=%h req=%b urgent=%b ages=%0d/%0d/%0d/%0d busy=%b, want all 0",
                     sensor_clean, req, urgent, age_n, age_s, age_e, age_w, busy);
        end
        rst = 1'b1;
        tick(3);
        n_vec++;
        if (sensor_clean !== 8'h00) begin
            n_err++;
            $display("FAIL reset_clean_3: got %h want 00", sensor_clean);
        end
        tick(1);
        n_vec++;
        if (sensor_clean !== 8'hFF || busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_clean_4: clean=%h busy=%b want FF 1", sensor_clean, busy);
        end
        tick(1);
        n_vec++;
        if (req !== 4'b1111) begin
            n_err++;
            $display("FAIL reset_req_all: got %b want 1111", req);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        sensor_raw[6] = 1'b1;
        tick(3);
        sensor_raw[6] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            n_vec++;
            if (sensor_clean[6] !== 1'b0 || req[0] !== 1'b0) begin
                n_err++;
                $display("FAIL glitch_short[%0d]: clean6=%b req0=%b want 0 0", i, sensor_clean[6], req[0]);
            end
        end
        sensor_raw[6] = 1'b1;
        tick(3);
        n_vec++;
        if (sensor_clean[6] !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_3cyc: clean6=%b want 0", sensor_clean[6]);
        end
        tick(1);
        n_vec++;
        if (sensor_clean[6] !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_4cyc: clean6=%b want 1", sensor_clean[6]);
        end
    endtask

    task automatic test_request_serve();
        do_reset();
        sensor_raw[6] = 1'b1;
        tick(4);
        tick(1);
        n_vec++;
        if (req !== 4'b0001 || age_n !== 8'd0) begin
            n_err++;
            $display("FAIL rs_enter: req=%b age_n=%0d want 0001 0", req, age_n);
        end
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            n_vec++;
            if (req !== 4'b0001 || age_n !== 8'(k)) begin
                n_err++;
                $display("FAIL rs_age[%0d]: req=%b age_n=%0d want 0001 %0d", k, req, age_n, k);
            end
        end
        light_n = 3'b100;
        tick(1);
        n_vec++;
        if (req !== 4'b0000 || age_n !== 8'd0) begin
            n_err++;
            $display("FAIL rs_served: req=%b age_n=%0d want 0000 0", req, age_n);
        end
        light_n = 3'b000;
        tick(1);
        n_vec++;
        if (req !== 4'b0001 || age_n !== 8'd0) begin
            n_err++;
            $display("FAIL rs_rewait: req=%b age_n=%0d want 0001 0", req, age_n);
        end
        tick(1);
        n_vec++;
        if (age_n !== 8'd1) begin
            n_err++;
            $display("FAIL rs_rewait_age: age_n=%0d want 1", age_n);
        end
    endtask

    task automatic test_saturation();
        int exp_age;
        logic exp_urg;
        do_reset();
        sensor_raw[6] = 1'b1;
        tick(5);
        for (int k = 1; k <= 300; k++) begin
            tick(1);
            exp_age = (k > 255) ? 255 : k;
            exp_urg = (exp_age >= 200);
            n_vec++;
            if (age_n !== 8'(exp_age) || urgent !== {3'b000, exp_urg} || req[0] !== 1'b1) begin
                n_err++;
                $display("FAIL sat[%0d]: age_n=%0d urgent=%b req0=%b want %0d %b 1",
                         k, age_n, urgent, req[0], exp_age, {3'b000, exp_urg});
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        sensor_raw[5] = 1'b1;
        tick(4);
        light_e = 3'b010;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            n_vec++;
            if (req[2] !== 1'b0 || age_e !== 8'd0) begin
                n_err++;
                $display("FAIL simul_served[%0d]: req2=%b age_e=%0d want 0 0", i, req[2], age_e);
            end
        end
        light_e = 3'b000;
        tick(1);
        n_vec++;
        if (req !== 4'b0100 || age_e !== 8'd0) begin
            n_err++;
            $display("FAIL simul_wait: req=%b age_e=%0d want 0100 0", req, age_e);
        end
        sensor_raw[5] = 1'b0;
        tick(4);
        n_vec++;
        if (req[2] !== 1'b1 || sensor_clean[5] !== 1'b0 || age_e !== 8'd4) begin
            n_err++;
            $display("FAIL simul_leave_pre: req2=%b clean5=%b age_e=%0d want 1 0 4", req[2], sensor_clean[5], age_e);
        end
        tick(1);
        n_vec++;
        if (req[2] !== 1'b0 || age_e !== 8'd0) begin
            n_err++;
            $display("FAIL simul_leave: req2=%b age_e=%0d want 0 0", req[2], age_e);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        sensor_raw[6] = 1'b1;
        tick(5);
        tick(50);
        n_vec++;
        if (age_n !== 8'd50 || req !== 4'b0001) begin
            n_err++;
            $display("FAIL ar_pre: age_n=%0d req=%b want 50 0001", age_n, req);
        end
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (req !== 4'b0000 || age_n !== 8'd0 || sensor_clean !== 8'h00) begin
            n_err++;
            $display("FAIL ar_clear: req=%b age_n=%0d clean=%h want 0000 0 00", req, age_n, sensor_clean);
        end
        #1;
        rst = 1'b1;
        tick(3);
        n_vec++;
        if (sensor_clean !== 8'h00 || req !== 4'b0000) begin
            n_err++;
            $display("FAIL ar_idle: clean=%h req=%b want 00 0000", sensor_clean, req);
        end
        tick(1);
        n_vec++;
        if (sensor_clean !== 8'h40 || req !== 4'b0000) begin
            n_err++;
            $display("FAIL ar_clean: clean=%h req=%b want 40 0000", sensor_clean, req);
        end
        tick(1);
        n_vec++;
        if (req !== 4'b0001 || age_n !== 8'd0) begin
            n_err++;
            $display("FAIL ar_rereq: req=%b age_n=%0d want 0001 0", req, age_n);
        end
    endtask

    initial begin
        rst = 1'b0;
        sensor_raw = 8'h00;
        light_n = 3'b000; light_s = 3'b000; light_e = 3'b000; light_w = 3'b000;
        test_reset();
        test_glitch();
        test_request_serve();
        test_saturation();
        test_simultaneous();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
